// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with branch/call redirect, return-address stack, stall and sticky halt
module pc_unit #(
    parameter int WIDTH     = 16,
    parameter int INCR      = 2,
    parameter int RESET_VEC = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             hlt,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             halted,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;   // index of the current top entry
    logic [CNT_W-1:0] ras_cnt;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic             active;
    logic             do_pop;
    logic             do_push;

    // wraps naturally from the top of the address space
    assign pc_plus   = pc + WIDTH'(INCR);

    // pointer arithmetic is explicit modulo so non-power-of-two depths work
    assign ptr_inc   = (ras_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr + PTR_W'(1);
    assign ptr_dec   = (ras_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr - PTR_W'(1);

    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));

    // an edge is "active" when neither halt nor stall freezes the unit;
    // ret outranks call so a simultaneous pair never pushes
    assign active    = !halted && !hlt && !stall;
    assign do_pop    = active && ret;
    assign do_push   = active && !ret && call;

    // PC, halt flag and RAS bookkeeping, in next-PC priority order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= WIDTH'(RESET_VEC);
            halted  <= 1'b0;
            ras_err <= 1'b0;
            ras_cnt <= '0;
            ras_ptr <= '0;
        end else if (!halted) begin
            if (hlt) begin
                halted <= 1'b1;
            end else if (!stall) begin
                if (do_pop) begin
                    if (ras_empty) begin
                        // underflow: fall through to the next instruction
                        pc      <= pc_plus;
                        ras_err <= 1'b1;
                    end else begin
                        pc      <= ras_mem[ras_ptr];
                        ras_cnt <= ras_cnt - CNT_W'(1);
                        ras_ptr <= ptr_dec;
                    end
                end else if (do_push) begin
                    pc      <= br_target;
                    ras_ptr <= ptr_inc;
                    if (ras_full) begin
                        // overflow: the push overwrote the oldest entry
                        ras_err <= 1'b1;
                    end else begin
                        ras_cnt <= ras_cnt + CNT_W'(1);
                    end
                end else if (br_taken) begin
                    pc <= br_target;
                end else begin
                    pc <= pc_plus;
                end
            end
        end
    end

    // return-address storage; entries are not cleared by reset
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            ras_mem[ptr_inc] <= pc_plus;
        end
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle/pipelined CPU core. Holds the fetch PC, selects the next PC from sequential increment, branch target, call target or a hardware return-address stack (RAS), and implements stall and sticky halt. Sits at the front of fetch and drives the instruction-memory address.

## Interface
- WIDTH, 16: PC and address width in bits.
- INCR, 2: sequential byte increment per instruction.
- RESET_VEC, 0: PC value loaded by reset.
- RAS_DEPTH, 4: return-address stack entries; must be ≥2.
- clk  in  1  sole clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and RAS this cycle.
- hlt  in  1  halt request from decode.
- br_taken  in  1  taken branch/jump; redirect to br_target.
- br_target  in  WIDTH  branch or call destination.
- call  in  1  push pc_plus onto RAS and redirect to br_target.
- ret  in  1  pop RAS top into PC.
- pc  out  WIDTH  current fetch PC (registered).
- pc_plus  out  WIDTH  pc + INCR (combinational).
- halted  out  1  sticky halt flag (registered).
- ras_empty  out  1  RAS count == 0 (registered state).
- ras_full  out  1  RAS count == RAS_DEPTH (registered state).
- ras_err  out  1  sticky: set on any overflow push or underflow pop.

## Operation
- Next-PC priority per edge, highest first: rst, halted, hlt, stall, ret, call, br_taken, sequential.
- halted = 1: PC, RAS, flags frozen; all inputs ignored until rst.
- hlt = 1 (not yet halted): PC holds (stays at halt instruction address), halted set on that edge; RAS untouched.
- stall = 1: PC and RAS hold; ret/call/br_taken that cycle are discarded (requester re-asserts).
- ret: PC <= RAS top, count decrements. If empty: PC <= pc_plus, count stays 0, ras_err set.
- call: PC <= br_target, RAS pushes pc_plus, count increments. br_taken irrelevant when call = 1.
- call on full: circular push overwrites oldest entry, count stays RAS_DEPTH, ras_err set.
- call and ret together: ret wins, call ignored, no error.
- br_taken only: PC <= br_target.
- Sequential: PC <= pc_plus.
- Arithmetic: pc_plus = (pc + INCR) mod 2^WIDTH; wrap from top of address space is legal, not an error.
- RAS: circular buffer with top pointer (log2 RAS_DEPTH bits) and count (0..RAS_DEPTH); pointer wraps mod RAS_DEPTH.

## Timing
- Reset (async, immediate on rst rise): pc = RESET_VEC, halted = 0, ras_err = 0, count = 0 (ras_empty = 1, ras_full = 0), pointer = 0; RAS entries need not be cleared. pc_plus = RESET_VEC + INCR.
- Deassertion of rst: first posedge with rst = 0 applies the normal next-PC rule.
- Latency: one cycle input-to-pc; pc_plus is zero-latency from pc.
- ras_empty/full/err update on the same edge as the push/pop that causes them.
- rst asserted mid-stall, mid-halt or mid-call: reset wins instantly; no partial state survives.

## Test plan
- Reset then free-run, INCR=2, RESET_VEC=0: pc = 0,2,4,6 on successive edges; pc_plus = pc+2.
- Branch then stall: at pc=6 br_taken, br_target=0x40 -> pc=0x40; stall 3 cycles -> pc stays 0x40; release -> 0x42.
- Call/return nesting: calls at pc=0x10 (target 0x100) and 0x102 (target 0x200) -> pc=0x200, count 2; two rets -> pc=0x104 then 0x12; ras_empty=1, ras_err=0.
- RAS overflow/underflow, RAS_DEPTH=4: 5 calls -> ras_full=1, ras_err=1, 4 rets return the 4 newest addresses; 5th ret -> pc=pc_plus, ras_err stays 1; ret on empty after fresh reset -> ras_err=1.
- Halt: at pc=0x20 hlt=1 -> pc holds 0x20, halted=1; further br_taken/call/ret ignored 5 cycles; async rst mid-cycle -> pc=0 immediately, halted=0.
- Wrap and parameters, WIDTH=8, INCR=4, RESET_VEC=0xF8: pc = 0xF8, 0xFC, 0x00, 0x04; call+ret same cycle with nonempty RAS -> pop taken, count decremented, no push.
